// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link: FSM encodings and default word size,
// so the serializer and the downstream deserializer agree on framing.
package piso_serializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a word over valid/ready and emits one bit
// per advancing clock, with stall, frame_last marker and zero-gap reload.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no word held; load_ready=1, serial_valid=0
// ST_SHIFT | word held; bit selected by count is on serial_out
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] data_reg;
  logic [CW-1:0]    count;
  logic [CW-1:0]    bit_idx;
  logic             is_last;

  assign is_last      = (state == ST_SHIFT) && (count == LAST_CNT);
  assign frame_last   = is_last;
  assign serial_valid = (state == ST_SHIFT);
  assign load_ready   = (state == ST_IDLE) || (is_last && shift_en);

  // The word is held unshifted; the counter selects which bit is presented.
  assign bit_idx    = MSB_FIRST ? (LAST_CNT - count) : count;
  assign serial_out = (state == ST_SHIFT) ? data_reg[bit_idx] : 1'b0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      data_reg <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            state    <= ST_SHIFT;
            data_reg <= load_data;
            count    <= '0;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (count == LAST_CNT) begin
              // Reload on the last consumed bit keeps back-to-back words gapless.
              if (load_valid) begin
                data_reg <= load_data;
                count    <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
